// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for the operand-stage pipeline control
//            (forward-select encoding, EX/MEM stage records, PC register index).
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Register address width the stage records are built with
    localparam int PKG_REG_AW = 4;

    // Architectural register that holds the PC; it is never forwarded
    localparam int unsigned PC_REG_DEFAULT = 15;

    // Operand-mux select encoding shared with the datapath
    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,  // regfile read
        FWD_ALU     = 2'b01,  // ALU result of the instruction in EX
        FWD_LDR     = 2'b10,  // load data of the instruction in MEM
        FWD_SPECIAL = 2'b11   // pc_out on A, constant zero on shift
    } fwd_sel_e;

    // Instruction occupying EX: may produce an ALU result and/or a load
    typedef struct packed {
        logic                  valid;
        logic                  alu_wen;
        logic [PKG_REG_AW-1:0] alu_dest;
        logic                  ldr_wen;
        logic [PKG_REG_AW-1:0] ldr_dest;
    } ex_stage_t;

    // Instruction occupying MEM: only its load result is still outstanding
    typedef struct packed {
        logic                  valid;
        logic                  ldr_wen;
        logic [PKG_REG_AW-1:0] ldr_dest;
    } mem_stage_t;

endpackage
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_match
// Brief    : Per-source operand forward select. Priority: special (PC on A,
//            zero on unused shift) > EX ALU result > MEM load data > regfile.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_match
    import pipe_pkg::*;
#(
    parameter int          REG_AW    = 4,
    parameter int unsigned PC_REG    = 15,
    parameter bit          PC_RULE   = 1'b0,   // source A: PC read selects pc_out
    parameter bit          ZERO_RULE = 1'b0    // shift source: unused selects zero
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic              src_used,
    input  logic              ex_valid,
    input  logic              ex_alu_wen,
    input  logic [REG_AW-1:0] ex_alu_dest,
    input  logic              mem_valid,
    input  logic              mem_ldr_wen,
    input  logic [REG_AW-1:0] mem_ldr_dest,
    output fwd_sel_e          sel
);

    localparam logic [REG_AW-1:0] PC_IDX = PC_REG[REG_AW-1:0];

    logic w_not_pc;

    // Priority select; EX is checked before MEM because it is the newer producer
    always_comb begin
        sel      = FWD_RF;
        w_not_pc = (src_addr != PC_IDX);
        if (PC_RULE && src_used && !w_not_pc) begin
            sel = FWD_SPECIAL;
        end else if (ZERO_RULE && !src_used) begin
            sel = FWD_SPECIAL;
        end else if (!src_used) begin
            sel = FWD_RF;
        end else if (w_not_pc && ex_valid && ex_alu_wen && (ex_alu_dest == src_addr)) begin
            sel = FWD_ALU;
        end else if (w_not_pc && mem_valid && mem_ldr_wen && (mem_ldr_dest == src_addr)) begin
            sel = FWD_LDR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_ctrl
// Brief    : Operand-capture stage controller. Tracks EX/MEM producers, drives
//            operand forward selects and capture enables, stalls one cycle on
//            load-use, handles branch flush and counts stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int          REG_AW = PKG_REG_AW,   // must match the stage records
    parameter int unsigned PC_REG = PC_REG_DEFAULT,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] a_addr,
    input  logic [REG_AW-1:0] b_addr,
    input  logic [REG_AW-1:0] s_addr,
    input  logic              a_used,
    input  logic              b_used,
    input  logic              s_used,
    input  logic              alu_wen,
    input  logic [REG_AW-1:0] alu_dest,
    input  logic              ldr_wen,
    input  logic [REG_AW-1:0] ldr_dest,
    input  logic              flush,
    output logic [1:0]        sel_A_in,
    output logic [1:0]        sel_B_in,
    output logic [1:0]        sel_shift_in,
    output logic              en_A,
    output logic              en_B,
    output logic              en_S,
    output logic              issue_accept,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [REG_AW-1:0] PC_IDX = PC_REG[REG_AW-1:0];

    ex_stage_t         ex_q,  ex_d;
    mem_stage_t        mem_q, mem_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    fwd_sel_e          w_sel_a, w_sel_b, w_sel_s;
    logic              w_raw_a, w_raw_b, w_raw_s;
    logic              w_stall, w_accept;

    fwd_match #(
        .REG_AW(REG_AW), .PC_REG(PC_REG), .PC_RULE(1'b1), .ZERO_RULE(1'b0)
    ) u_match_a (
        .src_addr(a_addr), .src_used(a_used),
        .ex_valid(ex_q.valid), .ex_alu_wen(ex_q.alu_wen), .ex_alu_dest(ex_q.alu_dest),
        .mem_valid(mem_q.valid), .mem_ldr_wen(mem_q.ldr_wen), .mem_ldr_dest(mem_q.ldr_dest),
        .sel(w_sel_a)
    );

    fwd_match #(
        .REG_AW(REG_AW), .PC_REG(PC_REG), .PC_RULE(1'b0), .ZERO_RULE(1'b0)
    ) u_match_b (
        .src_addr(b_addr), .src_used(b_used),
        .ex_valid(ex_q.valid), .ex_alu_wen(ex_q.alu_wen), .ex_alu_dest(ex_q.alu_dest),
        .mem_valid(mem_q.valid), .mem_ldr_wen(mem_q.ldr_wen), .mem_ldr_dest(mem_q.ldr_dest),
        .sel(w_sel_b)
    );

    fwd_match #(
        .REG_AW(REG_AW), .PC_REG(PC_REG), .PC_RULE(1'b0), .ZERO_RULE(1'b1)
    ) u_match_s (
        .src_addr(s_addr), .src_used(s_used),
        .ex_valid(ex_q.valid), .ex_alu_wen(ex_q.alu_wen), .ex_alu_dest(ex_q.alu_dest),
        .mem_valid(mem_q.valid), .mem_ldr_wen(mem_q.ldr_wen), .mem_ldr_dest(mem_q.ldr_dest),
        .sel(w_sel_s)
    );

    // Load-use detection against the EX load; flush overrides the stall.
    // issue_accept is also held low while reset is asserted.
    always_comb begin
        w_raw_a  = a_used && (a_addr != PC_IDX) && (ex_q.ldr_dest == a_addr);
        w_raw_b  = b_used && (b_addr != PC_IDX) && (ex_q.ldr_dest == b_addr);
        w_raw_s  = s_used && (s_addr != PC_IDX) && (ex_q.ldr_dest == s_addr);
        w_stall  = issue_valid && ex_q.valid && ex_q.ldr_wen &&
                   (w_raw_a || w_raw_b || w_raw_s) && !flush;
        w_accept = rst_n && issue_valid && !w_stall && !flush;
    end

    // Next-state: EX takes the issue or a bubble, MEM takes EX unless flushed
    always_comb begin
        ex_d = '0;
        if (w_accept) begin
            ex_d.valid    = 1'b1;
            ex_d.alu_wen  = alu_wen;
            ex_d.alu_dest = alu_dest;
            ex_d.ldr_wen  = ldr_wen;
            ex_d.ldr_dest = ldr_dest;
        end
        mem_d.valid    = ex_q.valid && !flush;
        mem_d.ldr_wen  = ex_q.ldr_wen;
        mem_d.ldr_dest = ex_q.ldr_dest;
        stall_count_d  = stall_count_q;
        if (w_stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Stage registers and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign sel_A_in     = w_sel_a;
    assign sel_B_in     = w_sel_b;
    assign sel_shift_in = w_sel_s;
    assign en_A         = w_accept;
    assign en_B         = w_accept;
    assign en_S         = w_accept;
    assign issue_accept = w_accept;
    assign stall        = w_stall;
    assign stall_count  = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_ctrl
// Brief    : Self-checking bench for fwd_hazard_ctrl: vector table plus
//            stall-saturation and asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    localparam int CNT_W = 8;

    logic             clk, rst_n;
    logic             issue_valid, a_used, b_used, s_used, alu_wen, ldr_wen, flush;
    logic [3:0]       a_addr, b_addr, s_addr, alu_dest, ldr_dest;
    logic [1:0]       sel_A_in, sel_B_in, sel_shift_in;
    logic             en_A, en_B, en_S, issue_accept, stall;
    logic [CNT_W-1:0] stall_count;

    fwd_hazard_ctrl #(.REG_AW(4), .PC_REG(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .a_addr(a_addr), .b_addr(b_addr), .s_addr(s_addr),
        .a_used(a_used), .b_used(b_used), .s_used(s_used),
        .alu_wen(alu_wen), .alu_dest(alu_dest), .ldr_wen(ldr_wen), .ldr_dest(ldr_dest),
        .flush(flush),
        .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in),
        .en_A(en_A), .en_B(en_B), .en_S(en_S),
        .issue_accept(issue_accept), .stall(stall), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       iv;
        logic [3:0] aa; logic au;
        logic [3:0] ba; logic bu;
        logic [3:0] sa; logic su;
        logic       aw; logic [3:0] ad;
        logic       lw; logic [3:0] ld;
        logic       fl;
        logic [1:0] esa, esb, ess;
        logic       eacc, estl;
        logic [7:0] ecnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [18:0] v;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[20];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        input logic iv, input logic [3:0] aa, input logic au, input logic [3:0] ba, input logic bu,
        input logic [3:0] sa, input logic su, input logic aw, input logic [3:0] ad,
        input logic lw, input logic [3:0] ld, input logic fl,
        input logic [1:0] esa, input logic [1:0] esb, input logic [1:0] ess,
        input logic eacc, input logic estl, input logic [7:0] ecnt);
        vec_t v;
        v.iv = iv; v.aa = aa; v.au = au; v.ba = ba; v.bu = bu; v.sa = sa; v.su = su;
        v.aw = aw; v.ad = ad; v.lw = lw; v.ld = ld; v.fl = fl;
        v.esa = esa; v.esb = esb; v.ess = ess; v.eacc = eacc; v.estl = estl; v.ecnt = ecnt;
        return v;
    endfunction

    function automatic logic [18:0] exp_of(input vec_t v);
        return {v.esa, v.esb, v.ess, {4{v.eacc}}, v.estl, v.ecnt};
    endfunction

    task automatic check(input string name, input logic [18:0] exp);
        logic [18:0] act;
        act = {sel_A_in, sel_B_in, sel_shift_in, issue_accept, en_A, en_B, en_S, stall, stall_count};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {selA,selB,selS,acc,enA,enB,enS,stall,cnt}=%b_%b_%b_%b_%b_%h expected %b_%b_%b_%b_%b_%h t=%0t",
                     name, act[18:17], act[16:15], act[14:13], act[12:9], act[8], act[7:0],
                     exp[18:17], exp[16:15], exp[14:13], exp[12:9], exp[8], exp[7:0], $time);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv;
        a_addr = v.aa; a_used = v.au;
        b_addr = v.ba; b_used = v.bu;
        s_addr = v.sa; s_used = v.su;
        alu_wen = v.aw; alu_dest = v.ad;
        ldr_wen = v.lw; ldr_dest = v.ld;
        flush = v.fl;
    endtask

    // One cycle: drive after the edge, expectation checked on the next negedge
    task automatic step(input vec_t v, input string name);
        sb_t e;
        @(posedge clk);
        #1;
        drive(v);
        e.name = name;
        e.v    = exp_of(v);
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: compare DUT outputs mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            check(sb_q[0].name, sb_q[0].v);
            void'(sb_q.pop_front());
        end
    end

    initial begin
        logic       ex_ld, mem_ld, stl;
        int         cnt_m;
        vec_t       v;

        //        iv aa au ba bu sa su aw ad lw ld fl  esa    esb    ess    acc stl cnt
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 8'd0); // idle after reset
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd0); // ADD r1
        tbl[2]  = mk(1, 1, 1, 0, 0, 0, 1, 1, 4, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 8'd0); // SUB reads r1 (EX fwd)
        tbl[3]  = mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd0); // r1 committed
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd0); // LDR r2
        tbl[5]  = mk(1, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 8'd0); // load-use stall
        tbl[6]  = mk(1, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0, 8'd1); // MEM load fwd
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd1); // LDR r3
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd1); // ALU r3
        tbl[9]  = mk(1, 0, 0, 3, 1, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0, 8'd1); // EX beats MEM
        tbl[10] = mk(1, 15,1, 0, 0, 0, 0, 1, 15,0, 0, 0, 2'b11, 2'b00, 2'b11, 1, 0, 8'd1); // PC on A, zero shift
        tbl[11] = mk(1, 15,1, 15,1, 15,1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0, 8'd1); // PC never forwarded
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd1); // LDR r5
        tbl[13] = mk(1, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 8'd1); // flush beats stall
        tbl[14] = mk(1, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd1); // killed load not fwd
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 1, 6, 1, 6, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd1); // dual write r6
        tbl[16] = mk(1, 6, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 1, 8'd1); // dual: ALU sel + stall
        tbl[17] = mk(1, 6, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0, 8'd2); // dual: load sel
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 8'd2); // flush drops issue
        tbl[19] = mk(1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 8'd2); // dropped ALU r7 absent

        rst_n = 1'b0;
        drive(tbl[0]);
        #1;
        check("reset_state", exp_of(tbl[0]));
        #11;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Repeated self-dependent load: alternate stall/accept until the counter saturates
        ex_ld  = 1'b0;
        mem_ld = 1'b0;
        cnt_m  = 2;
        for (int i = 0; i < 599; i++) begin
            stl = ex_ld;
            v = mk(1, 0, 0, 2, 1, 0, 1, 0, 0, 1, 2, 0,
                   2'b00, mem_ld ? 2'b10 : 2'b00, 2'b00, !stl, stl, 8'(cnt_m));
            step(v, "saturate");
            if (stl && cnt_m < 255) cnt_m++;
            mem_ld = ex_ld;
            ex_ld  = !stl;
        end

        // Assert reset in the middle of a stall cycle
        @(posedge clk);
        #1;
        drive(v);
        #2;
        check("pre_reset_stall", {2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 8'hFF});
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 8'h00});
        #2;
        rst_n = 1'b1;
        #1;
        check("post_reset_no_stall", {2'b00, 2'b00, 2'b00, 4'b1111, 1'b0, 8'h00});

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
